// File: rtl/mux_take_blk_tree_pkg.sv
// Shared definitions for the take-block mux tree: default sizes, tree indexing
// helpers and the pang-range test reused by the ping-pong controller.
package mux_take_blk_tree_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_IN = 16;

    typedef enum logic {
        RANGE_LINEAR = 1'b0,
        RANGE_WRAP   = 1'b1
    } range_mode_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int p = 1; p < value; p = p * 2) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Tree nodes are stored level by level: inputs first, root last.
    function automatic int tree_base(input int num_in, input int level);
        return 2 * num_in - 2 * (num_in >> level);
    endfunction

    function automatic logic in_range(
        input logic [31:0] start_idx,
        input logic [31:0] end_idx,
        input logic [31:0] idx,
        input range_mode_e mode
    );
        logic hit;
        if (start_idx <= end_idx) begin
            hit = (start_idx <= idx) && (idx <= end_idx);
        end else if (mode == RANGE_WRAP) begin
            hit = (idx >= start_idx) || (idx <= end_idx);
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

endpackage

// File: rtl/mux_take_blk_tree_mux2.sv
// Registered 2:1 mux node with pipeline enable; one instance per tree node.
module mux2_reg_en #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every node samples
    // the previous level's value from before the edge, never a same-edge update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= sel ? b : a;
        end
    end

endmodule

// File: rtl/mux_take_blk_tree.sv
// Pipelined NUM_IN:1 sub-block mux with an aligned take-block flag and valid
// pipeline; one tree level per advancing cycle, latency SEL_W.
module mux_take_blk_tree
    import mux_take_blk_tree_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_IN     = DEF_NUM_IN,
    parameter int SEL_W      = clog2(NUM_IN),
    parameter int WRAP_RANGE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     valid_i,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_IN*DATA_W-1:0] subblki,
    input  logic                     needpang,
    input  logic                     myturnpingpong,
    input  logic [SEL_W-1:0]         needpangstartinc,
    input  logic [SEL_W-1:0]         needpangendinc,
    output logic [DATA_W-1:0]        subblko,
    output logic                     takeblko,
    output logic                     valid_o
);

    localparam range_mode_e MODE = (WRAP_RANGE != 0) ? RANGE_WRAP : RANGE_LINEAR;
    localparam int NODES = 2 * NUM_IN - 1;

    logic [DATA_W-1:0] tree [NODES];
    logic [SEL_W-1:0]  level_sel;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_leaf
        assign tree[k] = subblki[k*DATA_W +: DATA_W];
    end

    // Level i must see sel[i] from the token now at its inputs, i.e. delayed i stages.
    assign level_sel[0] = sel[0];

    for (genvar i = 1; i < SEL_W; i++) begin : g_sel_dly
        logic [i-1:0] dly;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                dly <= '0;
            end else if (en) begin
                dly[0] <= sel[i];
                for (int m = 1; m < i; m++) begin
                    dly[m] <= dly[m-1];
                end
            end
        end

        assign level_sel[i] = dly[i-1];
    end

    for (genvar l = 0; l < SEL_W; l++) begin : g_level
        for (genvar j = 0; j < (NUM_IN >> (l + 1)); j++) begin : g_node
            mux2_reg_en #(
                .DATA_W(DATA_W)
            ) u_mux (
                .clk  (clk),
                .reset(reset),
                .en   (en),
                .sel  (level_sel[l]),
                .a    (tree[tree_base(NUM_IN, l) + 2*j]),
                .b    (tree[tree_base(NUM_IN, l) + 2*j + 1]),
                .q    (tree[tree_base(NUM_IN, l + 1) + j])
            );
        end
    end

    assign subblko = tree[NODES-1];

    logic                t0;
    logic                t1;
    logic [SEL_W-3:0]    take_pipe;
    logic [SEL_W-1:0]    valid_pipe;
    logic                range_hit;

    assign range_hit = in_range(32'(needpangstartinc), 32'(needpangendinc), 32'(sel), MODE);

    // needpang and myturnpingpong arrive one and two advancing cycles after sel,
    // so they are consumed live at the stage where their token sits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t0         <= 1'b0;
            t1         <= 1'b0;
            take_pipe  <= '0;
            valid_pipe <= '0;
        end else if (en) begin
            t0           <= !range_hit;
            t1           <= t0 | needpang;
            take_pipe[0] <= t1 & myturnpingpong;
            for (int k = 1; k < SEL_W - 2; k++) begin
                take_pipe[k] <= take_pipe[k-1];
            end
            valid_pipe[0] <= valid_i;
            for (int k = 1; k < SEL_W; k++) begin
                valid_pipe[k] <= valid_pipe[k-1];
            end
        end
    end

    assign takeblko = take_pipe[SEL_W-3];
    assign valid_o  = valid_pipe[SEL_W-1];

endmodule

// File: tb/tb_mux_take_blk_tree.sv
// Directed and randomised bench for mux_take_blk_tree; a linear and a wrapped
// instance share stimulus and are checked against a token scoreboard.
module tb_mux_take_blk_tree;

    localparam int DATA_W = 8;
    localparam int NUM_IN = 16;
    localparam int SEL_W  = 4;
    localparam int L      = SEL_W;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              take0;
        logic              take1;
        int                t;
    } tok_t;

    logic                     clk;
    logic                     reset;
    logic                     en;
    logic                     valid_i;
    logic [SEL_W-1:0]         sel;
    logic [NUM_IN*DATA_W-1:0] subblki;
    logic                     needpang;
    logic                     myturnpingpong;
    logic [SEL_W-1:0]         needpangstartinc;
    logic [SEL_W-1:0]         needpangendinc;
    logic [DATA_W-1:0]        dout0, dout1;
    logic                     take0, take1;
    logic                     vout0, vout1;

    mux_take_blk_tree #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .WRAP_RANGE(0)) u_lin (
        .clk(clk), .reset(reset), .en(en), .valid_i(valid_i), .sel(sel),
        .subblki(subblki), .needpang(needpang), .myturnpingpong(myturnpingpong),
        .needpangstartinc(needpangstartinc), .needpangendinc(needpangendinc),
        .subblko(dout0), .takeblko(take0), .valid_o(vout0)
    );

    mux_take_blk_tree #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .WRAP_RANGE(1)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .valid_i(valid_i), .sel(sel),
        .subblki(subblki), .needpang(needpang), .myturnpingpong(myturnpingpong),
        .needpangstartinc(needpangstartinc), .needpangendinc(needpangendinc),
        .subblko(dout1), .takeblko(take1), .valid_o(vout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   adv_cnt  = 0;
    int   rs       = 0;
    int   re       = 0;
    logic np_d1    = 1'b0;
    logic mt_d1    = 1'b1;
    logic mt_d2    = 1'b1;
    tok_t sb[$];
    logic              exp_v  = 1'b0;
    logic [DATA_W-1:0] exp_d  = '0;
    logic              exp_t0 = 1'b0;
    logic              exp_t1 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_hit(input int s, input int a, input int b, input bit wrap);
        if (a <= b) return (s >= a) && (s <= b);
        if (wrap) return (s >= a) || (s <= b);
        return 1'b0;
    endfunction

    task automatic check_outputs(input logic adv);
        tok_t tok;
        if (adv) begin
            if (sb.size() > 0 && sb[0].t == adv_cnt) begin
                tok    = sb.pop_front();
                exp_v  = 1'b1;
                exp_d  = tok.data;
                exp_t0 = tok.take0;
                exp_t1 = tok.take1;
            end else begin
                exp_v = 1'b0;
            end
        end
        chk("valid_lin", 32'(vout0), 32'(exp_v));
        chk("valid_wrap", 32'(vout1), 32'(exp_v));
        if (exp_v) begin
            chk("data_lin", 32'(dout0), 32'(exp_d));
            chk("data_wrap", 32'(dout1), 32'(exp_d));
            chk("take_lin", 32'(take0), 32'(exp_t0));
            chk("take_wrap", 32'(take1), 32'(exp_t1));
        end
    endtask

    // One clock of stimulus. np/mt belong to the token driven now and are
    // presented one and two advancing cycles later; stalled cycles drive the
    // inverse so any sampling during a stall corrupts the take flag.
    task automatic step(input logic e, input logic v, input int s, input logic np, input logic mt);
        tok_t tok;
        en               = e;
        valid_i          = v;
        sel              = SEL_W'(s);
        needpangstartinc = SEL_W'(rs);
        needpangendinc   = SEL_W'(re);
        needpang         = e ? np_d1 : ~np_d1;
        myturnpingpong   = e ? mt_d2 : ~mt_d2;
        if (e && v) begin
            tok.data  = DATA_W'(s + 'h10);
            tok.take0 = (!ref_hit(s, rs, re, 1'b0) | np) & mt;
            tok.take1 = (!ref_hit(s, rs, re, 1'b1) | np) & mt;
            tok.t     = adv_cnt + L;
            sb.push_back(tok);
        end
        @(posedge clk);
        #1;
        if (e) begin
            adv_cnt++;
            mt_d2 = mt_d1;
            mt_d1 = mt;
            np_d1 = np;
        end
        check_outputs(e);
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_data_lin"}, 32'(dout0), 32'h0);
        chk({tag, "_take_lin"}, 32'(take0), 32'h0);
        chk({tag, "_valid_lin"}, 32'(vout0), 32'h0);
        chk({tag, "_data_wrap"}, 32'(dout1), 32'h0);
        chk({tag, "_take_wrap"}, 32'(take1), 32'h0);
        chk({tag, "_valid_wrap"}, 32'(vout1), 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; valid_i = 1'b0; sel = '0;
        needpang = 1'b0; myturnpingpong = 1'b0;
        needpangstartinc = '0; needpangendinc = '0;
        for (int k = 0; k < NUM_IN; k++) subblki[k*DATA_W +: DATA_W] = DATA_W'(k + 'h10);

        repeat (2) @(posedge clk);
        #1;
        check_reset_zero("por");
        reset = 1'b1;

        // Back-to-back sweep; range 4..9 covers both edges of the take window.
        rs = 4; re = 9;
        for (int s = 0; s < NUM_IN; s++) step(1'b1, 1'b1, s, 1'b0, 1'b1);
        idle(L + 1);

        // needpang forces take, myturn gates it.
        step(1'b1, 1'b1, 5, 1'b1, 1'b1);
        step(1'b1, 1'b1, 5, 1'b1, 1'b0);
        idle(L + 1);

        // Reversed range: wrapped on one instance, empty on the other.
        rs = 12; re = 2;
        step(1'b1, 1'b1, 14, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 7, 1'b0, 1'b1);
        step(1'b1, 1'b1, 12, 1'b0, 1'b1);
        step(1'b1, 1'b1, 2, 1'b0, 1'b1);
        idle(L + 1);

        // Stall with a pending needpang/myturn token.
        rs = 4; re = 9;
        step(1'b1, 1'b1, 6, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle(L + 1);

        // Randomised enable/valid/range traffic.
        for (int i = 0; i < 40; i++) begin
            rs = int'($urandom_range(0, NUM_IN - 1));
            re = int'($urandom_range(0, NUM_IN - 1));
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, NUM_IN - 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rs = 4; re = 9;
        idle(2 * L);

        // Asynchronous reset with tokens in flight.
        step(1'b1, 1'b1, 2, 1'b0, 1'b1);
        step(1'b1, 1'b1, 3, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_reset_zero("async_rst");
        sb.delete();
        exp_v = 1'b0;
        np_d1 = 1'b0; mt_d1 = 1'b1; mt_d2 = 1'b1;
        @(posedge clk);
        #1;
        check_reset_zero("rst_hold");
        #1 reset = 1'b1;
        idle(3);
        step(1'b1, 1'b1, 11, 1'b0, 1'b1);
        idle(L + 2);

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
